// File: rtl/pc_irq_ctrl.sv
// pc_irq_ctrl
//   Program counter with a prioritised, nestable interrupt controller. The PC
//   advances, jumps or vectors once per instruction write-back (rising edge of
//   write_back). Return address and active priority are pushed on an internal
//   stack of NEST_DEPTH entries when an interrupt is taken, and popped on reti.
// Ports
//   clk, reset     clock, asynchronous active-high reset
//   write_back     retire strobe; a step is its 0->1 transition
//   jump, offset   retiring instruction jumps (PC-relative when offset=1)
//   reti           retiring instruction is return-from-interrupt
//   jump_addr      absolute target or signed offset
//   int_in         rising-edge interrupt requests, index 0 highest priority
//   int_mask       1 = channel held pending, not taken
//   pc_out         current program counter
//   int_pending    latched, unserviced request edges
//   int_level      active priority, N_INT when no handler runs
//   stack_depth    return-stack entries in use
//   stack_err      sticky: reti on empty stack, or IRQ blocked by full stack
module pc_irq_ctrl #(
   parameter int                ADDR_W     = 27,
   parameter logic [ADDR_W-1:0] PC_START   = 27'hC01400,
   parameter logic [ADDR_W-1:0] ROM_START  = 27'hC01400,
   parameter int                N_INT      = 4,
   parameter int                VEC_BASE   = 1,
   parameter int                NEST_DEPTH = 2,
   localparam int               LVL_W      = $clog2(N_INT + 1),
   localparam int               DEP_W      = $clog2(NEST_DEPTH + 1)
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              write_back,
   input  logic              jump,
   input  logic              offset,
   input  logic              reti,
   input  logic [ADDR_W-1:0] jump_addr,
   input  logic [N_INT-1:0]  int_in,
   input  logic [N_INT-1:0]  int_mask,
   output logic [ADDR_W-1:0] pc_out,
   output logic [N_INT-1:0]  int_pending,
   output logic [LVL_W-1:0]  int_level,
   output logic [DEP_W-1:0]  stack_depth,
   output logic              stack_err
);

   logic [ADDR_W-1:0] pc_q, pc_d;
   logic [N_INT-1:0]  pend_q, pend_d;
   logic [N_INT-1:0]  int_prev_q;
   logic              wb_prev_q;
   logic [LVL_W-1:0]  level_q, level_d;
   logic [DEP_W-1:0]  depth_q, depth_d;
   logic              err_q, err_d;
   logic [ADDR_W-1:0] stk_pc_q  [NEST_DEPTH];
   logic [ADDR_W-1:0] stk_pc_d  [NEST_DEPTH];
   logic [LVL_W-1:0]  stk_lvl_q [NEST_DEPTH];
   logic [LVL_W-1:0]  stk_lvl_d [NEST_DEPTH];

   logic              step;
   logic [N_INT-1:0]  cand;
   logic [N_INT-1:0]  clr;
   logic              k_valid;
   logic [LVL_W-1:0]  k;
   logic [ADDR_W-1:0] next_seq;
   logic [ADDR_W-1:0] pop_pc;
   logic [LVL_W-1:0]  pop_lvl;

   always_comb begin
      step     = write_back & ~wb_prev_q;
      cand     = pend_q & ~int_mask;
      clr      = '0;
      k_valid  = 1'b0;
      k        = '0;
      // Descending scan so the lowest eligible index wins.
      for (int i = N_INT - 1; i >= 0; i--) begin
         if (cand[i]) begin
            k_valid = 1'b1;
            k       = LVL_W'(i);
         end
      end
      // Address the instruction would produce without an interrupt; this is
      // also the return address pushed when an interrupt is taken.
      if (jump)
         next_seq = offset ? pc_q + jump_addr : jump_addr;
      else
         next_seq = pc_q + 1'b1;

      pop_pc  = pc_q;
      pop_lvl = level_q;
      for (int i = 0; i < NEST_DEPTH; i++) begin
         if (depth_q == DEP_W'(i + 1)) begin
            pop_pc  = stk_pc_q[i];
            pop_lvl = stk_lvl_q[i];
         end
      end

      pc_d    = pc_q;
      level_d = level_q;
      depth_d = depth_q;
      err_d   = err_q;
      for (int i = 0; i < NEST_DEPTH; i++) begin
         stk_pc_d[i]  = stk_pc_q[i];
         stk_lvl_d[i] = stk_lvl_q[i];
      end

      if (step) begin
         if (reti) begin
            if (depth_q != '0) begin
               pc_d    = pop_pc;
               level_d = pop_lvl;
               depth_d = depth_q - 1'b1;
            end else begin
               err_d = 1'b1;
               pc_d  = pc_q + 1'b1;
            end
         end else if (k_valid && (k < level_q) && (pc_q < ROM_START)) begin
            if (depth_q < DEP_W'(NEST_DEPTH)) begin
               for (int i = 0; i < NEST_DEPTH; i++) begin
                  if (depth_q == DEP_W'(i)) begin
                     stk_pc_d[i]  = next_seq;
                     stk_lvl_d[i] = level_q;
                  end
               end
               depth_d = depth_q + 1'b1;
               pc_d    = ADDR_W'(VEC_BASE) + ADDR_W'(k);
               level_d = k;
               clr[k]  = 1'b1;
            end else begin
               // Full stack: request stays pending, instruction retires normally.
               err_d = 1'b1;
               pc_d  = next_seq;
            end
         end else begin
            pc_d = next_seq;
         end
      end

      // A new edge wins over the clear of the channel being taken.
      pend_d = (pend_q & ~clr) | (int_in & ~int_prev_q);
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         pc_q       <= PC_START;
         pend_q     <= '0;
         int_prev_q <= '0;
         wb_prev_q  <= 1'b0;
         level_q    <= LVL_W'(N_INT);
         depth_q    <= '0;
         err_q      <= 1'b0;
         for (int i = 0; i < NEST_DEPTH; i++) begin
            stk_pc_q[i]  <= '0;
            stk_lvl_q[i] <= '0;
         end
      end else begin
         pc_q       <= pc_d;
         pend_q     <= pend_d;
         int_prev_q <= int_in;
         wb_prev_q  <= write_back;
         level_q    <= level_d;
         depth_q    <= depth_d;
         err_q      <= err_d;
         for (int i = 0; i < NEST_DEPTH; i++) begin
            stk_pc_q[i]  <= stk_pc_d[i];
            stk_lvl_q[i] <= stk_lvl_d[i];
         end
      end
   end

   assign pc_out      = pc_q;
   assign int_pending = pend_q;
   assign int_level   = level_q;
   assign stack_depth = depth_q;
   assign stack_err   = err_q;

endmodule

// File: tb/tb_pc_irq_ctrl.sv
// Directed bench for pc_irq_ctrl: default instance (two-deep stack) plus a
// single-entry stack instance for the overflow case.
module tb_pc_irq_ctrl;

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic        write_back = 1'b0, jump = 1'b0, offset = 1'b0, reti = 1'b0;
   logic [26:0] jump_addr = '0;
   logic [3:0]  int_in = '0, int_mask = '0;
   logic [26:0] pc_out;
   logic [3:0]  int_pending;
   logic [2:0]  int_level;
   logic [1:0]  stack_depth;
   logic        stack_err;

   logic        wb1 = 1'b0, jump1 = 1'b0, offset1 = 1'b0, reti1 = 1'b0;
   logic [26:0] jump_addr1 = '0;
   logic [3:0]  int_in1 = '0, int_mask1 = '0;
   logic [26:0] pc_out1;
   logic [3:0]  int_pending1;
   logic [2:0]  int_level1;
   logic [0:0]  stack_depth1;
   logic        stack_err1;

   int n_checks = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

   pc_irq_ctrl dut (
      .clk(clk), .reset(reset), .write_back(write_back), .jump(jump),
      .offset(offset), .reti(reti), .jump_addr(jump_addr), .int_in(int_in),
      .int_mask(int_mask), .pc_out(pc_out), .int_pending(int_pending),
      .int_level(int_level), .stack_depth(stack_depth), .stack_err(stack_err)
   );

   pc_irq_ctrl #(.NEST_DEPTH(1)) dut1 (
      .clk(clk), .reset(reset), .write_back(wb1), .jump(jump1),
      .offset(offset1), .reti(reti1), .jump_addr(jump_addr1), .int_in(int_in1),
      .int_mask(int_mask1), .pc_out(pc_out1), .int_pending(int_pending1),
      .int_level(int_level1), .stack_depth(stack_depth1), .stack_err(stack_err1)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp)
      else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic step(input logic j, input logic o, input logic r, input logic [26:0] a);
      @(negedge clk);
      jump = j; offset = o; reti = r; jump_addr = a; write_back = 1'b1;
      @(negedge clk);
      write_back = 1'b0; jump = 1'b0; offset = 1'b0; reti = 1'b0;
   endtask

   task automatic step1(input logic j, input logic [26:0] a);
      @(negedge clk);
      jump1 = j; jump_addr1 = a; wb1 = 1'b1;
      @(negedge clk);
      wb1 = 1'b0; jump1 = 1'b0;
   endtask

   task automatic pulse(input int idx);
      @(negedge clk);
      int_in[idx] = 1'b1;
      @(negedge clk);
      int_in[idx] = 1'b0;
   endtask

   task automatic pulse1(input int idx);
      @(negedge clk);
      int_in1[idx] = 1'b1;
      @(negedge clk);
      int_in1[idx] = 1'b0;
   endtask

   task automatic chk_main(input string tag, input logic [26:0] pc, input logic [2:0] lvl,
                           input logic [1:0] dep, input logic [3:0] pend);
      chk({tag, "_pc"}, 32'(pc_out), 32'(pc));
      chk({tag, "_lvl"}, 32'(int_level), 32'(lvl));
      chk({tag, "_dep"}, 32'(stack_depth), 32'(dep));
      chk({tag, "_pend"}, 32'(int_pending), 32'(pend));
   endtask

   initial begin
      // T1 reset and sequential steps
      reset = 1'b1;
      #12 reset = 1'b0;
      @(negedge clk);
      chk_main("t1_rst", 27'hC01400, 3'd4, 2'd0, 4'h0);
      chk("t1_rst_err", 32'(stack_err), 32'd0);
      step(0, 0, 0, '0); chk("t1_s1", 32'(pc_out), 32'hC01401);
      step(0, 0, 0, '0); chk("t1_s2", 32'(pc_out), 32'hC01402);
      step(0, 0, 0, '0); chk_main("t1_s3", 27'hC01403, 3'd4, 2'd0, 4'h0);

      // T2 relative jump retiring while ch2 is taken, then reti
      step(1, 0, 0, 27'h100); chk("t2_abs", 32'(pc_out), 32'h100);
      pulse(2); chk("t2_pend", 32'(int_pending), 32'h4);
      step(1, 1, 0, 27'h10); chk_main("t2_take", 27'h3, 3'd2, 2'd1, 4'h0);
      step(0, 0, 1, '0); chk_main("t2_reti", 27'h110, 3'd4, 2'd0, 4'h0);

      // T3 nesting: ch0 preempts ch2, ch3 waits for level to drop
      pulse(2);
      step(0, 0, 0, '0); chk_main("t3_ch2", 27'h3, 3'd2, 2'd1, 4'h0);
      step(0, 0, 0, '0); chk("t3_h2", 32'(pc_out), 32'h4);
      pulse(0); pulse(3); chk("t3_pend", 32'(int_pending), 32'h9);
      step(0, 0, 0, '0); chk_main("t3_ch0", 27'h1, 3'd0, 2'd2, 4'h8);
      step(0, 0, 0, '0); chk_main("t3_h0", 27'h2, 3'd0, 2'd2, 4'h8);
      step(0, 0, 1, '0); chk_main("t3_reti1", 27'h5, 3'd2, 2'd1, 4'h8);
      step(0, 0, 1, '0); chk_main("t3_reti2", 27'h111, 3'd4, 2'd0, 4'h8);
      step(0, 0, 0, '0); chk_main("t3_ch3", 27'h4, 3'd3, 2'd1, 4'h0);
      step(0, 0, 1, '0); chk_main("t3_reti3", 27'h112, 3'd4, 2'd0, 4'h0);

      // T4 no interrupts while executing from ROM
      step(1, 0, 0, 27'hC01400); chk("t4_rom", 32'(pc_out), 32'hC01400);
      pulse(1);
      step(0, 0, 0, '0); chk_main("t4_hold", 27'hC01401, 3'd4, 2'd0, 4'h2);
      step(1, 0, 0, 27'h20); chk_main("t4_jmp", 27'h20, 3'd4, 2'd0, 4'h2);
      step(0, 0, 0, '0); chk_main("t4_take", 27'h2, 3'd1, 2'd1, 4'h0);
      step(0, 0, 1, '0); chk_main("t4_reti", 27'h21, 3'd4, 2'd0, 4'h0);

      // T5a reti on empty stack
      chk("t5_err0", 32'(stack_err), 32'd0);
      step(0, 0, 1, '0); chk_main("t5_empty", 27'h22, 3'd4, 2'd0, 4'h0);
      chk("t5_err1", 32'(stack_err), 32'd1);

      // T5b single-entry stack: nested ch0 blocked, stays pending
      step1(1, 27'h200); chk("t5b_pc", 32'(pc_out1), 32'h200);
      pulse1(1);
      step1(0, '0);
      chk("t5b_take_pc", 32'(pc_out1), 32'h2);
      chk("t5b_take_lvl", 32'(int_level1), 32'd1);
      chk("t5b_take_err", 32'(stack_err1), 32'd0);
      pulse1(0);
      step1(0, '0);
      chk("t5b_ovf_pc", 32'(pc_out1), 32'h3);
      chk("t5b_ovf_pend", 32'(int_pending1), 32'h1);
      chk("t5b_ovf_lvl", 32'(int_level1), 32'd1);
      chk("t5b_ovf_dep", 32'(stack_depth1), 32'd1);
      chk("t5b_ovf_err", 32'(stack_err1), 32'd1);

      // T6 asynchronous reset with a handler active
      pulse(2);
      step(0, 0, 0, '0); chk_main("t6_pre", 27'h3, 3'd2, 2'd1, 4'h0);
      pulse(3); chk("t6_pend", 32'(int_pending), 32'h8);
      @(negedge clk);
      #2 reset = 1'b1;
      #1;
      chk_main("t6_rst", 27'hC01400, 3'd4, 2'd0, 4'h0);
      chk("t6_rst_err", 32'(stack_err), 32'd0);
      chk("t6_rst1_pc", 32'(pc_out1), 32'hC01400);
      #10 reset = 1'b0;

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
